mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: max ACCESS cycles waiting for DataReady before bus error (range 1..255).
REQ-002 Clk  input  1  system clock; all state on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  CPU request strobe, sampled only in IDLE.
REQ-005 Op  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 VAddr  input  32  byte address from CPU.
REQ-007 WData  input  32  store data, right-justified.
REQ-008 Busy  output  1  high in every state except IDLE.
REQ-009 Done  output  1  one-cycle completion pulse.
REQ-010 RData  output  32  aligned, extended load result.
REQ-011 AddrErr  output  1  one-cycle misalignment pulse.
REQ-012 BusErr  output  1  one-cycle timeout pulse, coincident with Done.
REQ-013 CS  output  1  memory chip select.
REQ-014 RW  output  1  1 = write, 0 = read.
REQ-015 BE  output  4  byte-lane enables, BE[3] = bits 31:24.
REQ-016 Addr  output  32  word address to memory, Addr[1:0] = 00.
REQ-017 MemWData  output  32  lane-positioned store data to memory DataIn.
REQ-018 MemRData  input  32  memory DataOut.
REQ-019 DataReady  input  1  memory completion flag.
REQ-020 MemSign  output  1  tied 0; extension is done here, not in memory.

Function
REQ-021 FSM states IDLE, ACCESS, DONE; IDLE -> ACCESS on Start with aligned request.
REQ-022 Start with misaligned request (LW/SW VAddr[1:0]!=00; LH/LHU/SH VAddr[0]=1) SHALL pulse AddrErr next cycle, stay IDLE, assert no CS.
REQ-023 On accept, Op, VAddr[1:0], WData latched; CPU inputs ignored until IDLE re-entered.
REQ-024 In ACCESS: CS=1, Addr={VAddr[31:2],00}, RW=1 for SW/SH/SB else 0, all held stable.
REQ-025 BE: word 1111; half at offset 0 -> 0011, offset 2 -> 1100; byte at offset n -> lane n only.
REQ-026 MemWData: WData[15:0] or WData[7:0] replicated across all lanes for SH/SB; WData for SW.
REQ-027 ACCESS -> DONE on first rising edge with DataReady=1 (minimum one ACCESS cycle); MemRData captured on that edge for loads.
REQ-028 Load result: selected lane(s) shifted to bits [15:0]/[7:0]; LH/LB sign-extend, LHU/LBU zero-extend, LW unmodified.
REQ-029 ACCESS cycle counter; reaching TIMEOUT cycles without DataReady -> DONE with BusErr=1; RData unchanged.
REQ-030 DONE lasts exactly one cycle: Done=1, CS=0, then IDLE; RData holds until next successful load.
REQ-031 Aligned-access latency with DataReady tied 1: Start edge -> Done high 2 cycles later; back-to-back Start accepted in the cycle after DONE.
REQ-032 Stores complete with Done=1; RData unchanged by stores.
REQ-033 Outside ACCESS: CS=0, RW=0, BE=0000.

Reset
REQ-034 Reset asserted at any time, including mid-ACCESS, SHALL force IDLE immediately; CS, RW, Busy, Done, AddrErr, BusErr=0; BE=0000; Addr, MemWData, RData=0; counter=0.
REQ-035 After reset release, first accepted Start behaves as a fresh request; no pending access resumes.

Verification
REQ-036 LW VAddr=0x00000004, MemRData=0x00000002, DataReady=1 -> CS=1, BE=1111, RW=0 for 1 cycle; Done 2 cycles after Start; RData=0x00000002.
REQ-037 LB VAddr=0x00000003, MemRData=0x80FF0000 -> BE=1000, RData=0xFFFFFF80; LBU same -> RData=0x00000080.
REQ-038 SH VAddr=0x00000002, WData=0x1234ABCD -> BE=1100, RW=1, MemWData=0xABCDABCD, Done pulse, RData unchanged.
REQ-039 LH VAddr=0x00000001 -> AddrErr pulse next cycle, CS never asserted, Busy stays 0.
REQ-040 DataReady held 0, TIMEOUT=15 -> CS high 15 cycles, then Done=1 and BusErr=1 same cycle, return to IDLE.
REQ-041 Reset pulsed during ACCESS -> CS, Busy drop asynchronously; no Done; next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU and word-organised memory. It checks alignment, drives
// lane enables and positioned store data, extends load results, and times out stalled accesses.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] VAddr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        AddrErr,
  output logic        BusErr,
  output logic        CS,
  output logic        RW,
  output logic [3:0]  BE,
  output logic [31:0] Addr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        DataReady,
  output logic        MemSign
);

  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [2:0]  op_reg;
  logic [1:0]  off_reg;
  logic [7:0]  cnt;

  logic        misaligned;
  logic        is_store;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_val;

  assign MemSign = 1'b0;
  assign is_store = Op[2] & (Op[1] | Op[0]);

  // Request decode works on the live CPU inputs; only used at the accept edge.
  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b0001 << VAddr[1:0];
    wdata_calc = WData;
    case (Op)
      OP_LW, OP_SW: begin
        misaligned = (VAddr[1:0] != 2'b00);
        be_calc    = 4'b1111;
      end
      OP_LH, OP_LHU, OP_SH: begin
        misaligned = VAddr[0];
        be_calc    = VAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    if (Op == OP_SH) wdata_calc = {2{WData[15:0]}};
    if (Op == OP_SB) wdata_calc = {4{WData[7:0]}};
  end

  // Load extraction uses the latched op/offset so the CPU bus may change during ACCESS.
  always_comb begin
    half_sel = off_reg[1] ? MemRData[31:16] : MemRData[15:0];
    case (off_reg)
      2'd0:    byte_sel = MemRData[7:0];
      2'd1:    byte_sel = MemRData[15:8];
      2'd2:    byte_sel = MemRData[23:16];
      default: byte_sel = MemRData[31:24];
    endcase
    case (op_reg)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = MemRData;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      op_reg   <= 3'd0;
      off_reg  <= 2'd0;
      cnt      <= 8'd0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      AddrErr  <= 1'b0;
      BusErr   <= 1'b0;
      CS       <= 1'b0;
      RW       <= 1'b0;
      BE       <= 4'b0000;
      Addr     <= 32'd0;
      MemWData <= 32'd0;
      RData    <= 32'd0;
    end else begin
      Done    <= 1'b0;
      AddrErr <= 1'b0;
      BusErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (misaligned) begin
              AddrErr <= 1'b1;
            end else begin
              state    <= ACCESS;
              Busy     <= 1'b1;
              CS       <= 1'b1;
              RW       <= is_store;
              BE       <= be_calc;
              Addr     <= {VAddr[31:2], 2'b00};
              MemWData <= wdata_calc;
              op_reg   <= Op;
              off_reg  <= VAddr[1:0];
              cnt      <= 8'd0;
            end
          end
        end
        ACCESS: begin
          // DataReady on the final allowed cycle still counts as a successful access.
          if (DataReady || cnt == 8'(TIMEOUT - 1)) begin
            state <= DONE;
            Done  <= 1'b1;
            CS    <= 1'b0;
            RW    <= 1'b0;
            BE    <= 4'b0000;
            if (!DataReady) BusErr <= 1'b1;
            else if (!RW) RData <= load_val;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stimulus pushes expected responses into a queue,
// a monitor pops and compares whenever the DUT shows CS, Done or AddrErr.
module tb_mem_access_unit;

  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;
  localparam int K_DONE = 0, K_AERR = 1, K_ABORT = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] VAddr = 32'd0;
  logic [31:0] WData = 32'd0;
  logic [31:0] MemRData = 32'd0;
  logic        DataReady = 1'b1;
  logic        Busy, Done, AddrErr, BusErr, CS, RW, MemSign;
  logic [31:0] RData, Addr, MemWData;
  logic [3:0]  BE;

  typedef struct {
    int          kind;
    logic [3:0]  be;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] mw;
    int          cs_cycles;
    logic        buserr;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .VAddr(VAddr), .WData(WData),
    .Busy(Busy), .Done(Done), .RData(RData), .AddrErr(AddrErr), .BusErr(BusErr),
    .CS(CS), .RW(RW), .BE(BE), .Addr(Addr), .MemWData(MemWData),
    .MemRData(MemRData), .DataReady(DataReady), .MemSign(MemSign)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its Done or AddrErr.
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] wd,
                       input logic [31:0] mr, input logic dr, input int kind,
                       input logic [3:0] be, input logic rw, input logic [31:0] mw,
                       input int cs_cycles, input logic buserr, input logic [31:0] rdata);
    exp_t e;
    bit got;
    e.kind = kind; e.be = be; e.rw = rw; e.addr = {va[31:2], 2'b00}; e.mw = mw;
    e.cs_cycles = cs_cycles; e.buserr = buserr; e.rdata = rdata;
    @(posedge Clk);
    #1;
    Op = op; VAddr = va; WData = wd; MemRData = mr; DataReady = dr; Start = 1'b1;
    q.push_back(e);
    $display("issue op=%0d vaddr=%h wdata=%h memr=%h ready=%0d", op, va, wd, mr, dr);
    @(posedge Clk);
    #1;
    Start = 1'b0;
    VAddr = 32'hFFFF_FFFF;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (Done || AddrErr) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("response_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: compares access signals on CS rise and results on Done/AddrErr.
  initial begin : monitor
    exp_t e;
    bit cs_prev;
    int cs_cnt, cyc, start_cyc;
    cs_prev = 0; cs_cnt = 0; cyc = 0; start_cyc = 0;
    forever begin
      @(negedge Clk);
      cyc++;
      if (Reset) begin
        cs_prev = 0;
        cs_cnt = 0;
        if (q.size() > 0 && q[0].kind == K_ABORT) void'(q.pop_front());
        continue;
      end
      if (Start && !Busy) start_cyc = cyc;
      if (CS) begin
        if (!cs_prev) begin
          if (q.size() == 0) chk("cs_unexpected", 32'd1, 32'd0);
          else begin
            chk("cs_on_misaligned", 32'(q[0].kind == K_AERR), 32'd0);
            chk("be", 32'(BE), 32'(q[0].be));
            chk("rw", 32'(RW), 32'(q[0].rw));
            chk("addr", Addr, q[0].addr);
            if (q[0].rw) chk("mem_wdata", MemWData, q[0].mw);
          end
        end
        cs_cnt++;
      end
      cs_prev = CS;
      if (Done || AddrErr) begin
        if (q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          if (Done) begin
            chk("done_kind", 32'(e.kind), K_DONE);
            chk("bus_err", 32'(BusErr), 32'(e.buserr));
            chk("rdata", RData, e.rdata);
            chk("cs_cycles", 32'(cs_cnt), 32'(e.cs_cycles));
            chk("done_latency", 32'(cyc - start_cyc), 32'(e.cs_cycles + 1));
            chk("done_cs_low", 32'(CS), 32'd0);
            $display("done  kind=%0d buserr=%0d rdata=%h cs_cycles=%0d", e.kind, BusErr, RData, cs_cnt);
          end else begin
            chk("aerr_kind", 32'(e.kind), K_AERR);
            chk("aerr_busy", 32'(Busy), 32'd0);
            chk("aerr_cs_cycles", 32'(cs_cnt), 32'd0);
            chk("aerr_latency", 32'(cyc - start_cyc), 32'd1);
            $display("aerr  busy=%0d cs_cycles=%0d", Busy, cs_cnt);
          end
        end
        cs_cnt = 0;
      end
    end
  end

  initial begin : stim
    #12;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_cs", 32'(CS), 32'd0);
    chk("rst_rw", 32'(RW), 32'd0);
    chk("rst_be", 32'(BE), 32'd0);
    chk("rst_addr", Addr, 32'd0);
    chk("rst_mwdata", MemWData, 32'd0);
    chk("rst_rdata", RData, 32'd0);
    chk("rst_errs", {30'd0, AddrErr, BusErr}, 32'd0);
    chk("mem_sign", 32'(MemSign), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    issue(LW,  32'h0000_0004, 32'h0,         32'h0000_0002, 1, K_DONE, 4'b1111, 0, 32'h0,         1, 0, 32'h0000_0002);
    issue(LB,  32'h0000_0003, 32'h0,         32'h80FF_0000, 1, K_DONE, 4'b1000, 0, 32'h0,         1, 0, 32'hFFFF_FF80);
    issue(LBU, 32'h0000_0003, 32'h0,         32'h80FF_0000, 1, K_DONE, 4'b1000, 0, 32'h0,         1, 0, 32'h0000_0080);
    issue(SH,  32'h0000_0002, 32'h1234_ABCD, 32'h5555_5555, 1, K_DONE, 4'b1100, 1, 32'hABCD_ABCD, 1, 0, 32'h0000_0080);
    issue(LH,  32'h0000_0001, 32'h0,         32'h0,         1, K_AERR, 4'b0000, 0, 32'h0,         0, 0, 32'h0);
    issue(LH,  32'h0000_1002, 32'h0,         32'h8001_7FFF, 1, K_DONE, 4'b1100, 0, 32'h0,         1, 0, 32'hFFFF_8001);
    issue(LHU, 32'h0000_1000, 32'h0,         32'h1234_F00D, 1, K_DONE, 4'b0011, 0, 32'h0,         1, 0, 32'h0000_F00D);
    issue(LB,  32'h0000_0011, 32'h0,         32'h0000_7F00, 1, K_DONE, 4'b0010, 0, 32'h0,         1, 0, 32'h0000_007F);
    issue(SB,  32'h0000_0022, 32'hFFFF_FF5A, 32'h0,         1, K_DONE, 4'b0100, 1, 32'h5A5A_5A5A, 1, 0, 32'h0000_007F);
    issue(SW,  32'h0000_0030, 32'hDEAD_BEEF, 32'h0,         1, K_DONE, 4'b1111, 1, 32'hDEAD_BEEF, 1, 0, 32'h0000_007F);
    issue(SW,  32'h0000_0031, 32'h0,         32'h0,         1, K_AERR, 4'b0000, 0, 32'h0,         0, 0, 32'h0);
    issue(LW,  32'h0000_0002, 32'h0,         32'h0,         1, K_AERR, 4'b0000, 0, 32'h0,         0, 0, 32'h0);
    issue(SH,  32'h0000_0003, 32'h0,         32'h0,         1, K_AERR, 4'b0000, 0, 32'h0,         0, 0, 32'h0);
    issue(LW,  32'h0000_0040, 32'h0,         32'h1111_1111, 0, K_DONE, 4'b1111, 0, 32'h0,        15, 1, 32'h0000_007F);

    // Abort an access with reset; nothing completes and RData clears.
    begin
      exp_t e;
      e.kind = K_ABORT; e.be = 4'b1111; e.rw = 0; e.addr = 32'h0000_0050; e.mw = 32'h0;
      e.cs_cycles = 0; e.buserr = 0; e.rdata = 32'h0;
      @(posedge Clk);
      #1;
      Op = LW; VAddr = 32'h0000_0050; DataReady = 1'b0; Start = 1'b1;
      q.push_back(e);
      $display("issue op=0 vaddr=00000050 ready=0 (reset abort)");
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (3) @(posedge Clk);
      #2;
      chk("pre_rst_cs", 32'(CS), 32'd1);
      Reset = 1'b1;
      #1;
      chk("abort_cs", 32'(CS), 32'd0);
      chk("abort_busy", 32'(Busy), 32'd0);
      chk("abort_done", 32'(Done), 32'd0);
      chk("abort_rdata", RData, 32'd0);
      @(negedge Clk);
      #1;
      Reset = 1'b0;
      DataReady = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      chk("post_rst_busy", 32'(Busy), 32'd0);
    end

    issue(LW,  32'h0000_0004, 32'h0,         32'hCAFE_F00D, 1, K_DONE, 4'b1111, 0, 32'h0,         1, 0, 32'hCAFE_F00D);
    repeat (4) @(posedge Clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
